// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the HI/LO multiply/divide sequencer.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational 32x32 multiply/divide datapath returning {hi,lo} and a divide-by-zero flag.
module mdu_alu
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] safe_b;
    logic [31:0] udiv_q;
    logic [31:0] udiv_r;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;

    // A zero divisor is swapped for 1 so the dividers never see it; the result is discarded anyway.
    assign safe_b = (b == 32'd0) ? 32'd1 : b;
    assign abs_a  = a[31] ? (32'd0 - a) : a;
    assign abs_b  = b[31] ? (32'd0 - b) : safe_b;

    assign udiv_q = a / safe_b;
    assign udiv_r = a % safe_b;
    assign mag_q  = abs_a / abs_b;
    assign mag_r  = abs_a % abs_b;
    assign sdiv_q = (a[31] ^ b[31]) ? (32'd0 - mag_q) : mag_q;
    assign sdiv_r = a[31] ? (32'd0 - mag_r) : mag_r;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        case (md_op_e'(op))
            MD_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            MD_MULTU: result = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                div_by_zero = (b == 32'd0);
                result      = {sdiv_r, sdiv_q};
            end
            MD_DIVU: begin
                div_by_zero = (b == 32'd0);
                result      = {udiv_r, udiv_q};
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer: owns HI/LO, models fixed latency and stalls D-stage MD ops.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_hilo_sel,
    input  logic        D_md_use,
    output logic [31:0] out_HI_LO,
    output logic        busy,
    output logic        stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic               busy_q, busy_d;

    md_op_e             op;
    logic               start_accepted;
    logic [63:0]        alu_result;
    logic               alu_div_by_zero;

    assign op             = md_op_e'(E_md_op);
    assign start_accepted = E_start & (state_q == IDLE) & (op != MD_NONE);

    mdu_alu u_alu (
        .op          (E_md_op),
        .a           (E_A),
        .b           (E_B),
        .result      (alu_result),
        .div_by_zero (alu_div_by_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            IDLE: begin
                if (start_accepted) begin
                    if (is_mul(op) || is_div(op)) begin
                        state_d   = BUSY;
                        cnt_d     = is_mul(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        pend_hi_d = alu_result[63:32];
                        pend_lo_d = alu_result[31:0];
                        pend_wr_d = ~alu_div_by_zero;
                    end else if (op == MD_MTHI) begin
                        hi_d = E_A;
                    end else if (op == MD_MTLO) begin
                        lo_d = E_A;
                    end
                end
            end
            BUSY: begin
                // Last busy cycle: commit (unless the divisor was zero) and release the unit.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == BUSY);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            busy_q    <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign stall     = D_md_use & (busy_q | start_accepted);
    assign out_HI_LO = E_hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_md_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_hilo_sel;
    logic        D_md_use;
    logic [31:0] out_HI_LO;
    logic        busy;
    logic        stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_start    (E_start),
        .E_md_op    (E_md_op),
        .E_A        (E_A),
        .E_B        (E_B),
        .E_hilo_sel (E_hilo_sel),
        .D_md_use   (D_md_use),
        .out_HI_LO  (out_HI_LO),
        .busy       (busy),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one MD op, from 64-bit integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output bit dz);
        longint          sp, sa, sb, q, r;
        longint unsigned up, ua, ub;
        hi = '0;
        lo = '0;
        dz = 1'b0;
        case (op)
            3'd1: begin
                sa = $signed(a);
                sb = $signed(b);
                sp = sa * sb;
                hi = sp[63:32];
                lo = sp[31:0];
            end
            3'd2: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                up = ua * ub;
                hi = up[63:32];
                lo = up[31:0];
            end
            3'd3: begin
                if (b == 32'd0) dz = 1'b1;
                else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            3'd4: begin
                if (b == 32'd0) dz = 1'b1;
                else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endfunction

    // Issue one op at cycle t (current cycle), follow it to completion and check timing and results.
    task automatic exec_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] nh, nl;
        bit          dz;
        int          n;
        int          cyc;
        model(op, a, b, nh, nl, dz);
        n = (op == 3'd1 || op == 3'd2) ? MC : (op == 3'd3 || op == 3'd4) ? DC : 0;

        E_start = 1'b1; E_md_op = op; E_A = a; E_B = b; D_md_use = 1'b1; E_hilo_sel = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL accept_stall: got %b expected 1", stall); end
        checks++;
        if (out_HI_LO !== exp_hi) begin errors++; $display("FAIL no_bypass: got %h expected %h", out_HI_LO, exp_hi); end

        step();
        E_start = 1'b0; E_md_op = 3'd0; E_A = $urandom; E_B = $urandom;
        #1;
        cyc = 0;
        while (busy === 1'b1 && cyc < n + 3) begin
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL busy_stall: got %b expected 1", stall); end
            checks++;
            if (out_HI_LO !== exp_hi) begin errors++; $display("FAIL busy_hold: got %h expected %h", out_HI_LO, exp_hi); end
            cyc++;
            if (inject && cyc == 2) begin
                E_start = 1'b1; E_md_op = 3'd5; E_A = 32'hDEADBEEF;
            end else begin
                E_start = 1'b0; E_md_op = 3'd0;
            end
            step();
        end
        E_start = 1'b0; E_md_op = 3'd0;
        #1;
        checks++;
        if (cyc !== n) begin errors++; $display("FAIL busy_cycles: got %0d expected %0d", cyc, n); end

        if (n == 0) begin
            if (op == 3'd5) exp_hi = nh;
            else exp_lo = nl;
        end else if (!dz) begin
            exp_hi = nh;
            exp_lo = nl;
        end

        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_clear: got %b expected 0", busy); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b expected 0", stall); end
        E_hilo_sel = 1'b1;
        #1;
        checks++;
        if (out_HI_LO !== exp_hi) begin errors++; $display("FAIL hi_result op=%0d: got %h expected %h", op, out_HI_LO, exp_hi); end
        E_hilo_sel = 1'b0;
        #1;
        checks++;
        if (out_HI_LO !== exp_lo) begin errors++; $display("FAIL lo_result op=%0d: got %h expected %h", op, out_HI_LO, exp_lo); end
    endtask

    task automatic test_reset();
        reset = 1'b0; E_start = 1'b0; E_md_op = 3'd0; E_A = '0; E_B = '0; E_hilo_sel = 1'b0; D_md_use = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++;
        if (out_HI_LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", out_HI_LO); end
        E_hilo_sel = 1'b1;
        #1;
        checks++;
        if (out_HI_LO !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", out_HI_LO); end
        step();
    endtask

    task automatic test_mult();
        exec_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        E_hilo_sel = 1'b1; #1;
        checks++;
        if (out_HI_LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", out_HI_LO); end
        E_hilo_sel = 1'b0; #1;
        checks++;
        if (out_HI_LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", out_HI_LO); end
        step();
        exec_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
        E_hilo_sel = 1'b1; #1;
        checks++;
        if (out_HI_LO !== 32'h00000002) begin errors++; $display("FAIL multu_hi: got %h expected 00000002", out_HI_LO); end
        step();
    endtask

    task automatic test_div();
        exec_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        E_hilo_sel = 1'b0; #1;
        checks++;
        if (out_HI_LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", out_HI_LO); end
        E_hilo_sel = 1'b1; #1;
        checks++;
        if (out_HI_LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", out_HI_LO); end
        step();
        exec_op(MD_DIVU, 32'd7, 32'd0, 1'b0);
        E_hilo_sel = 1'b0; #1;
        checks++;
        if (out_HI_LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL divu_zero_lo: got %h expected fffffffd", out_HI_LO); end
        step();
        exec_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        E_hilo_sel = 1'b1; #1;
        checks++;
        if (out_HI_LO !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", out_HI_LO); end
        step();
        exec_op(MD_DIV, 32'd100, 32'hFFFFFFF9, 1'b0);
        step();
    endtask

    task automatic test_stall();
        exec_op(MD_MULT, $urandom, $urandom, 1'b1);
        D_md_use = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL stall_no_use: got %b expected 0", stall); end
        step();
    endtask

    task automatic test_move();
        exec_op(MD_MTHI, 32'h12345678, 32'd0, 1'b0);
        exec_op(MD_MTLO, 32'h9ABCDEF0, 32'd0, 1'b0);
        step();
        E_hilo_sel = 1'b1; #1;
        checks++;
        if (out_HI_LO !== 32'h12345678) begin errors++; $display("FAIL mthi_read: got %h expected 12345678", out_HI_LO); end
        E_hilo_sel = 1'b0; #1;
        checks++;
        if (out_HI_LO !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo_read: got %h expected 9abcdef0", out_HI_LO); end
        step();
    endtask

    task automatic test_reset_midop();
        E_start = 1'b1; E_md_op = MD_DIV; E_A = 32'hFFFFFF9C; E_B = 32'd7; D_md_use = 1'b0;
        step();
        E_start = 1'b0; E_md_op = 3'd0;
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b expected 1", busy); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midop_abort: got %b expected 0", busy); end
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midop_idle: got %b expected 0", busy); end
        E_hilo_sel = 1'b1; #1;
        checks++;
        if (out_HI_LO !== 32'd0) begin errors++; $display("FAIL midop_hi: got %h expected 0", out_HI_LO); end
        E_hilo_sel = 1'b0; #1;
        checks++;
        if (out_HI_LO !== 32'd0) begin errors++; $display("FAIL midop_lo: got %h expected 0", out_HI_LO); end
        step();
        exec_op(MD_MULT, 32'h00012345, 32'hFFFF0003, 1'b0);
        step();
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 9));
                default: b = $urandom;
            endcase
            exec_op(op, a, b, (i % 7) == 3);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_move();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for the HI/LO multiply/divide resource of the 5-stage MIPS pipeline.
- Accepts one MD operation from the E stage and models fixed multi-cycle latency with a BUSY state. Commits results to the HI/LO registers it owns.
- Drives the selected HI/LO value to the pipeline, which is what the writeback stage receives as in_HI_LO.
- Generates the D-stage stall so that no MD instruction issues while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state
- E_start  in  1  E-stage instruction is an MD op; sampled only together with E_md_op
- E_md_op  in  3  operation code (package encoding)
- E_A  in  32  rs operand (forwarded)
- E_B  in  32  rt operand (forwarded)
- E_hilo_sel  in  1  read select: 0 = LO (mflo), 1 = HI (mfhi)
- D_md_use  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- out_HI_LO  out  32  HI or LO selected by E_hilo_sel, combinational from registers
- busy  out  1  unit occupied by mult/div
- stall  out  1  D_md_use & (busy | start_accepted)

Behaviour:
- Reset: HI=0, LO=0, busy=0, state=IDLE, counter=0, pending result=0. Reset mid-operation aborts the operation and leaves no commit.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, counter counts down.
- start_accepted = E_start & (state==IDLE) & (E_md_op != MD_NONE).
- If E_start arrives in BUSY, it is ignored. No state change occurs. The stall guarantees this is unreachable in legal flow.
- mult/multu/div/divu, start accepted at edge of cycle t:
  - Compute the 64-bit result {hi,lo} from E_A/E_B and latch it into the pending registers.
  - Load counter = N (MULT_CYCLES or DIV_CYCLES) and go to BUSY.
  - busy=1 during cycles t+1 .. t+N.
  - At the edge ending cycle t+N, HI/LO take the pending values and state returns to IDLE.
  - New HI/LO and busy=0 are both visible in cycle t+N+1.
- mthi/mtlo: the write to HI or LO occurs at the edge of cycle t. There is no BUSY state and no latency; the new value is visible in cycle t+1.
- Arithmetic:
  - mult: signed 32x32 -> 64, HI = [63:32], LO = [31:0].
  - multu: unsigned 32x32 -> 64.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (E_B==0, div or divu): the operation still occupies DIV_CYCLES, but HI/LO are left unchanged at commit.
- out_HI_LO always reflects the committed registers. No bypass of pending results. No bypass of an mthi/mtlo in the same cycle.
- stall is combinational:
  - In the cycle an op is accepted, a D-stage MD instruction is already stalled.
  - stall deasserts in cycle t+N+1.
- The counter never wraps. It is loaded only from IDLE and holds at 0 in IDLE.

Decomposition:
- Shared package (mdu_pkg):
  - MD op encoding: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - State encoding: IDLE=0, BUSY=1.
  - Default latency constants.
- One natural sub-module, mdu_alu: purely combinational, takes op, A and B, and returns the 64-bit {hi,lo} result plus a div_by_zero flag. The controller holds the FSM, counter and registers.

Test Plan:
- Mult: reset, then mult A=0xFFFFFFFE(-2) B=3.
  - busy=1 for exactly 5 cycles.
  - Cycle t+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- Multu, same operands:
  - HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- Div: div A=-7 B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> 10 busy cycles, HI/LO unchanged.
- Stall: D_md_use=1 held through a mult started at cycle t.
  - stall=1 from cycle t through t+5, 0 at t+6.
  - E_start during BUSY is ignored (HI/LO unaffected).
- Move/read: mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles.
  - busy stays 0.
  - out_HI_LO reads 0x12345678 with sel=1 and 0x9ABCDEF0 with sel=0 in the following cycles.
- Reset mid-op: div started, reset=0 at busy cycle 4.
  - Next cycle: busy=0, HI=LO=0, no later commit.
  - A subsequent mult completes normally.
